// File: rtl/ram_dp.sv
// Simple-dual-port synchronous RAM with byte enables and post-reset zero-fill.
// Read port is registered, valid-flagged, with an optional second output stage.
module ram_dp #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 10,
    parameter int OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  writeEn,
    input  logic [ADDR_W-1:0]     writeAdr,
    input  logic [DATA_W-1:0]     writeData,
    input  logic [DATA_W/8-1:0]   writeByteEn,
    input  logic                  readEn,
    input  logic [ADDR_W-1:0]     readAdr,
    output logic [DATA_W-1:0]     readData,
    output logic                  readValid,
    output logic                  initBusy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W:0]   fill_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              run;
    logic              same_adr;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    assign run      = (state == S_RUN);
    assign same_adr = (writeAdr == readAdr);
    assign initBusy = ~run;

    // Fill FSM: walk every word once after reset, then hand over to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            fill_cnt <= '0;
        end else if (state == S_INIT) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == LAST) begin
                state <= S_RUN;
            end
        end
    end

    // Memory array: zero-fill in INIT, byte-masked writes in RUN.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[fill_cnt[ADDR_W-1:0]] <= '0;
        end else if (writeEn) begin
            for (int i = 0; i < NB; i++) begin
                if (writeByteEn[i]) begin
                    mem[writeAdr][8*i +: 8] <= writeData[8*i +: 8];
                end
            end
        end
    end

    // Write-first bypass, per byte, when both ports hit the same word.
    always_comb begin
        rd_word = mem[readAdr];
        for (int i = 0; i < NB; i++) begin
            if (writeEn && writeByteEn[i] && same_adr) begin
                rd_word[8*i +: 8] = writeData[8*i +: 8];
            end
        end
    end

    // Read stage 1: capture on accepted read, data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= run && readEn;
            if (run && readEn) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] s2_data;
            logic              s2_valid;

            // Read stage 2: plain retiming copy of stage 1.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_data  <= s1_data;
                end
            end

            assign readData  = s2_data;
            assign readValid = s2_valid;
        end else begin : g_no_out_reg
            assign readData  = s1_data;
            assign readValid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp.sv
// Directed bench for ram_dp: one instance per read latency, shared stimulus.
// Expected values are hand-computed constants checked with immediate asserts.
module tb_ram_dp;

    localparam int DW = 64;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          writeEn;
    logic [AW-1:0] writeAdr;
    logic [DW-1:0] writeData;
    logic [7:0]    writeByteEn;
    logic          readEn;
    logic [AW-1:0] readAdr;
    logic [DW-1:0] rd0, rd1;
    logic          rv0, rv1;
    logic          ib0, ib1;

    int checks = 0;
    int passes = 0;

    ram_dp #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .writeEn(writeEn), .writeAdr(writeAdr),
        .writeData(writeData), .writeByteEn(writeByteEn),
        .readEn(readEn), .readAdr(readAdr),
        .readData(rd0), .readValid(rv0), .initBusy(ib0)
    );

    ram_dp #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .writeEn(writeEn), .writeAdr(writeAdr),
        .writeData(writeData), .writeByteEn(writeByteEn),
        .readEn(readEn), .readAdr(readAdr),
        .readData(rd1), .readValid(rv1), .initBusy(ib1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [63:0] bval(input int a);
        return 64'h0101_0101_0101_0000 + 64'(a);
    endfunction

    initial begin
        rst_n       = 1'b0;
        writeEn     = 1'b0;
        writeAdr    = '0;
        writeData   = '0;
        writeByteEn = '0;
        readEn      = 1'b0;
        readAdr     = '0;

        // Reset state
        tick();
        tick();
        check("rst_rd0", rd0, 0);
        check("rst_rv0", 64'(rv0), 0);
        check("rst_ib0", 64'(ib0), 1);
        check("rst_rd1", rd1, 0);
        check("rst_rv1", 64'(rv1), 0);
        check("rst_ib1", 64'(ib1), 1);

        // Fill phase with accesses attempted; write to addr 3 on fill cycle 2
        readEn  = 1'b1;
        readAdr = 4'd3;
        rst_n   = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            check("fill_ib0", 64'(ib0), (k < DEPTH) ? 64'd1 : 64'd0);
            check("fill_ib1", 64'(ib1), (k < DEPTH) ? 64'd1 : 64'd0);
            check("fill_rv0", 64'(rv0), 0);
            check("fill_rv1", 64'(rv1), 0);
            if (k == 1) begin
                writeEn     = 1'b1;
                writeAdr    = 4'd3;
                writeData   = 64'hAAAA_AAAA_AAAA_AAAA;
                writeByteEn = 8'hFF;
            end else begin
                writeEn = 1'b0;
            end
        end

        // Sweep all addresses: every word reads zero
        for (int a = 0; a < DEPTH; a++) begin
            readEn  = 1'b1;
            readAdr = 4'(a);
            tick();
            check("sweep_rv0", 64'(rv0), 1);
            check("sweep_rd0", rd0, 0);
        end
        readEn = 1'b0;
        tick();
        check("idle_rv0", 64'(rv0), 0);
        check("idle_rv1", 64'(rv1), 1);
        tick();
        check("idle_rv1b", 64'(rv1), 0);

        // Byte enables
        writeEn     = 1'b1;
        writeAdr    = 4'd5;
        writeData   = 64'h1122_3344_5566_7788;
        writeByteEn = 8'hFF;
        tick();
        writeData   = 64'hFFFF_FFFF_FFFF_FFFF;
        writeByteEn = 8'h0F;
        tick();
        writeData   = 64'h0;
        writeByteEn = 8'h00;
        tick();
        writeEn = 1'b0;
        readEn  = 1'b1;
        readAdr = 4'd5;
        tick();
        readEn = 1'b0;
        check("be_rv", 64'(rv0), 1);
        check("be_rd", rd0, 64'h1122_3344_FFFF_FFFF);
        tick();
        check("hold_rv", 64'(rv0), 0);
        check("hold_rd", rd0, 64'h1122_3344_FFFF_FFFF);

        // Read-during-write, same address
        writeEn     = 1'b1;
        writeAdr    = 4'd7;
        writeData   = 64'hDEAD_BEEF_CAFE_F00D;
        writeByteEn = 8'hF0;
        readEn      = 1'b1;
        readAdr     = 4'd7;
        tick();
        writeEn = 1'b0;
        readEn  = 1'b0;
        check("rdw_rv", 64'(rv0), 1);
        check("rdw_rd", rd0, 64'hDEAD_BEEF_0000_0000);
        tick();
        check("rdw_rd1", rd1, 64'hDEAD_BEEF_0000_0000);

        // Read-during-write, different addresses
        writeEn     = 1'b1;
        writeAdr    = 4'd2;
        writeData   = 64'h55;
        writeByteEn = 8'hFF;
        readEn      = 1'b1;
        readAdr     = 4'd5;
        tick();
        writeEn = 1'b0;
        readAdr = 4'd2;
        check("ind_rd", rd0, 64'h1122_3344_FFFF_FFFF);
        tick();
        readEn = 1'b0;
        check("ind_rd2", rd0, 64'h55);

        // Burst: fill 8..15, then 8 back-to-back reads
        writeEn     = 1'b1;
        writeByteEn = 8'hFF;
        for (int a = 8; a < 16; a++) begin
            writeAdr  = 4'(a);
            writeData = bval(a);
            tick();
        end
        writeEn = 1'b0;
        tick();
        for (int t = 0; t < 12; t++) begin
            readEn  = (t < 8);
            readAdr = 4'(8 + (t % 8));
            tick();
            check("bst_rv0", 64'(rv0), (t < 8) ? 64'd1 : 64'd0);
            if (t < 8) check("bst_rd0", rd0, bval(8 + t));
            check("bst_rv1", 64'(rv1),
                  (t >= 1 && t < 9) ? 64'd1 : 64'd0);
            if (t >= 1 && t < 9) check("bst_rd1", rd1, bval(7 + t));
        end
        readEn = 1'b0;

        // Mid-read reset
        readEn  = 1'b1;
        readAdr = 4'd7;
        tick();
        readEn = 1'b0;
        check("mr_pre_rv0", 64'(rv0), 1);
        check("mr_pre_rv1", 64'(rv1), 0);
        rst_n = 1'b0;
        #1;
        check("mr_rv0", 64'(rv0), 0);
        check("mr_rd0", rd0, 0);
        check("mr_ib0", 64'(ib0), 1);
        tick();
        check("mr_rv1", 64'(rv1), 0);
        check("mr_rd1", rd1, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            check("refill_ib0", 64'(ib0), (k < DEPTH) ? 64'd1 : 64'd0);
            check("refill_ib1", 64'(ib1), (k < DEPTH) ? 64'd1 : 64'd0);
        end
        readEn  = 1'b1;
        readAdr = 4'd7;
        tick();
        readEn = 1'b0;
        check("refill_rv", 64'(rv0), 1);
        check("refill_rd", rd0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
